// File: rtl/fetch_if.sv
// fetch_if: pipelined instruction-memory request/response bus between fetch and imem
interface fetch_if #(parameter int WORD = 32) ();
    logic            imemReq;
    logic [WORD-1:0] imemAddr;
    logic            imemRvalid;
    logic [WORD-1:0] imemRdata;
    modport master (output imemReq, imemAddr, input imemRvalid, imemRdata);
    modport slave  (input imemReq, imemAddr, output imemRvalid, imemRdata);
endinterface

// File: rtl/fetch.sv
// fetch: in-order imem fetch with prefetch queue and IF/ID register; FETCH_PERF_CNT_EN adds fetchCnt/bubbleCnt
module fetch #(
    parameter int              WORD     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            redirectE,
    input  logic [WORD-1:0] pcTargetE,
    fetch_if.master         imem,
    output logic [WORD-1:0] pcD,
    output logic [WORD-1:0] instrD,
    output logic            validD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [WORD-1:0] fetchCnt,
    output logic [WORD-1:0] bubbleCnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 8;

    logic [WORD-1:0]  fetch_pc;
    logic [WORD-1:0]  q_pc   [DEPTH];
    logic [WORD-1:0]  q_data [DEPTH];
    logic [DEPTH-1:0] q_full, set_m, clr_m;
    logic [PW-1:0]    head, tail, fptr;
    logic [CW-1:0]    count, pending;
    logic [DW-1:0]    discard, discard_n;
    logic             drop, fill, head_ok, issue, pop;
    logic [WORD-1:0]  head_data;
    logic             unused;

    assign unused    = ^pcTargetE[1:0];
    assign drop      = imem.imemRvalid && discard != '0;
    assign fill      = imem.imemRvalid && discard == '0;
    // a response landing on the empty head is forwarded straight into IF/ID
    assign head_ok   = count != '0 && (q_full[head] || (fill && fptr == head));
    assign head_data = q_full[head] ? q_data[head] : imem.imemRdata;
    assign issue     = count < CW'(DEPTH) && !redirectE;
    assign pop       = en && head_ok && !redirectE;
    assign set_m     = fill ? DEPTH'(1) << fptr : '0;
    assign clr_m     = pop ? DEPTH'(1) << head : '0;
    // on redirect every unreturned request becomes stale and must be swallowed
    assign discard_n = discard - DW'(drop) + (redirectE ? DW'(pending) - DW'(fill) : DW'(0));

    assign imem.imemReq  = issue;
    assign imem.imemAddr = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            count    <= '0;
            pending  <= '0;
            discard  <= '0;
            q_full   <= '0;
            validD   <= 1'b0;
            pcD      <= '0;
            instrD   <= WORD'(32'h0000_0013);
        end else begin
            discard <= discard_n;
            if (redirectE) begin
                fetch_pc <= {pcTargetE[WORD-1:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                fptr     <= '0;
                count    <= '0;
                pending  <= '0;
                q_full   <= '0;
                validD   <= 1'b0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + WORD'(4);
                    tail     <= tail + PW'(1);
                end
                if (fill) fptr <= fptr + PW'(1);
                if (pop) head <= head + PW'(1);
                q_full  <= (q_full | set_m) & ~clr_m;
                count   <= count + CW'(issue) - CW'(pop);
                pending <= pending + CW'(issue) - CW'(fill);
                if (en) begin
                    validD <= head_ok;
                    if (head_ok) begin
                        pcD    <= q_pc[head];
                        instrD <= head_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) q_pc[tail] <= fetch_pc;
        if (fill) q_data[fptr] <= imem.imemRdata;
    end

    always_ff @(posedge clk) begin
        if (!reset && imem.imemRvalid) assert (pending != '0 || discard != '0);
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (pop && fetchCnt != '1) fetchCnt <= fetchCnt + WORD'(1);
            if (en && !redirectE && !head_ok && bubbleCnt != '1) bubbleCnt <= bubbleCnt + WORD'(1);
        end
    end
`endif
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed vector table plus multi-cycle redirect/wrap/reset sequences against an in-order imem model
module tb_fetch;
    typedef struct {
        logic        en;
        logic        redir;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1, en = 1'b0, redirectE = 1'b0;
    logic [31:0] pcTargetE = '0, pcD, instrD;
    logic        validD;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetchCnt, bubbleCnt;
`endif
    fetch_if #(.WORD(32)) imem ();

    fetch #(.WORD(32), .DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .en(en), .redirectE(redirectE), .pcTargetE(pcTargetE),
        .imem(imem), .pcD(pcD), .instrD(instrD), .validD(validD)
`ifdef FETCH_PERF_CNT_EN
        , .fetchCnt(fetchCnt), .bubbleCnt(bubbleCnt)
`endif
    );

    always #5 clk = ~clk;

    vec_t        tbl[17];
    int          checks = 0, errors = 0, cyc = 0, lat = 1;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic        obs_req;
    logic [31:0] obs_addr;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: inputs and memory response at negedge, outputs sampled 1ns after posedge
    task automatic step(input logic e, input logic r, input logic [31:0] t, input logic rst);
        @(negedge clk);
        reset = rst; en = e; redirectE = r; pcTargetE = t;
        if (rst) begin
            q_addr.delete();
            q_due.delete();
        end
        imem.imemRvalid = 1'b0;
        imem.imemRdata  = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            imem.imemRvalid = 1'b1;
            imem.imemRdata  = word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        #1;
        obs_req  = imem.imemReq;
        obs_addr = imem.imemAddr;
        if (!rst && obs_req) begin
            q_addr.push_back(obs_addr);
            q_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stream(input logic [31:0] start, input int n, input string tag);
        logic [31:0] exp = start;
        int got = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (validD) begin
                chk({tag, " pc"}, pcD, exp);
                chk({tag, " instr"}, instrD, word(exp));
                exp += 32'd4;
                got++;
            end
        end
        chk({tag, " delivered>=3"}, 32'(got >= 3), 32'd1);
    endtask

    task automatic warm_l3();
        lat = 3;
        step(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
        chk("l3 two in flight", 32'(q_due.size()), 32'd2);
        step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
        chk("l3 redir req", 32'(obs_req), 32'd0);
        chk("l3 redir valid", 32'(validD), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("l3 target req", 32'(obs_req), 32'd1);
        chk("l3 target addr", obs_addr, 32'h0000_0100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, k;
        logic [31:0] exp;
        tbl = '{
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'hc,   1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h8},
            '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hc},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h10},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h14},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1c,  1'b1, 32'h18},
            '{1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   1'b0, 32'h18},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h18},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104}
        };
        imem.imemRvalid = 1'b0;
        imem.imemRdata  = '0;
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("reset validD", 32'(validD), 32'd0);
        chk("reset pcD", pcD, 32'h0);
        chk("reset instrD", instrD, 32'h13);

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].redir, tbl[i].tgt, 1'b0);
            chk($sformatf("vec%0d req", i), 32'(obs_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("vec%0d addr", i), obs_addr, tbl[i].addr);
            chk($sformatf("vec%0d validD", i), 32'(validD), 32'(tbl[i].valid));
            chk($sformatf("vec%0d pcD", i), pcD, tbl[i].pc);
            if (tbl[i].valid) chk($sformatf("vec%0d instrD", i), instrD, word(tbl[i].pc));
        end

        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap redir validD", 32'(validD), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("wrap addr top", obs_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("wrap addr zero", obs_addr, 32'h0);
        chk("wrap pc top", pcD, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("wrap pc zero", pcD, 32'h0);
        chk("wrap instr zero", instrD, word(32'h0));

        step(1'b1, 1'b0, '0, 1'b1);
        chk("midreset validD", 32'(validD), 32'd0);
        chk("midreset pcD", pcD, 32'h0);
        chk("midreset instrD", instrD, 32'h13);
        step(1'b1, 1'b0, '0, 1'b0);
        chk("midreset req", 32'(obs_req), 32'd1);
        chk("midreset addr", obs_addr, 32'h0);
        n = 0;
        k = 0;
        exp = 32'h0;
        while (n < 10 && k < 30) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (validD) begin
                chk("post-reset pc", pcD, exp);
                exp += 32'd4;
                n++;
            end
            k++;
        end
        chk("post-reset delivered", 32'(n), 32'd10);
`ifdef FETCH_PERF_CNT_EN
        chk("fetchCnt", fetchCnt, 32'd10);
        chk("bubbleCnt", bubbleCnt, 32'd1);
`endif

        warm_l3();
        stream(32'h0000_0100, 20, "redir1");

        warm_l3();
        step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("redir2 req", 32'(obs_req), 32'd0);
        stream(32'h0000_0200, 20, "redir2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
